// File: rtl/fre_div_pkg.sv
// Shared types and helpers for the multi-channel frequency divider.
//   CNT_W     : storage width of a channel config (CNT_WIDTH of the top
//               must not exceed it)
//   DIV_MIN   : smallest legal period in sclk cycles
//   ch_cfg_t  : {div, high} pair held as active or shadow config
//   cfg_valid : legality of a requested {div, high} pair
package fre_div_pkg;

  localparam int CNT_W   = 32;
  localparam int DIV_MIN = 2;

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] high;
  } ch_cfg_t;

  function automatic logic cfg_valid(input logic [CNT_W-1:0] div,
                                     input logic [CNT_W-1:0] high);
    return (div >= CNT_W'(DIV_MIN)) && (high <= div);
  endfunction

endpackage

// File: rtl/fre_div_ch.sv
// One divider channel: period counter, active and shadow config, pending
// flag and the registered div_clk / tick outputs.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : channel enable; low parks the counter at 0
//   sync_i       : restart the period on the next edge
//   wr_i         : accepted write targeting this channel (already checked)
//   wr_cfg_i     : config carried by that write
//   pending_o    : shadow holds a config not yet applied
//   div_clk_o    : high for the first 'high' cycles of each period
//   tick_o       : one-cycle pulse at period start
module fre_div_ch
  import fre_div_pkg::*;
#(
  parameter int unsigned DEF_DIV  = 125000000,
  parameter int unsigned DEF_HIGH = 62500000
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    en_i,
  input  logic    sync_i,
  input  logic    wr_i,
  input  ch_cfg_t wr_cfg_i,
  output logic    pending_o,
  output logic    div_clk_o,
  output logic    tick_o
);

  localparam ch_cfg_t DEF_CFG = '{div: CNT_W'(DEF_DIV), high: CNT_W'(DEF_HIGH)};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  ch_cfg_t          act_q, act_d, shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d, tick_q, tick_d;
  logic             wrap;

  always_comb begin
    cnt_d  = '0;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    wrap   = (cnt_q == act_q.div - CNT_W'(1));

    // Outputs reflect the counter value at this edge, so they trail cnt
    // by one cycle; sync and disable both park the counter at zero.
    if (en_i && !sync_i) begin
      clk_d  = (cnt_q < act_q.high);
      tick_d = (cnt_q == '0);
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    // Shadow only swaps in at a period boundary (or while idle), so a
    // running period is never cut short or stretched.
    if (pend_q && (!en_i || sync_i || wrap)) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end

    // A write in the same cycle as an application lands after it: the old
    // shadow goes active and the new one waits for the next boundary.
    if (wr_i) begin
      shd_d  = wr_cfg_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      act_q  <= DEF_CFG;
      shd_q  <= DEF_CFG;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pending_o = pend_q;
  assign div_clk_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/multi_fre_div.sv
// Multi-channel programmable divided-clock / tick generator.
//   sclk, rst  : system clock, synchronous active-high reset
//   en         : per-channel enable
//   sync       : realign all enabled channels to a period start
//   cfg_wr     : single-cycle write strobe for {cfg_div, cfg_high} to cfg_ch
//   cfg_err    : one-cycle pulse after a rejected write
//   pending    : per-channel shadow config waiting for a period boundary
//   div_clk    : per-channel divided output (registered)
//   tick       : per-channel period-start pulse (registered)
module multi_fre_div
  import fre_div_pkg::*;
#(
  parameter int          CH_NUM    = 4,
  parameter int          CNT_WIDTH = 32,
  parameter int unsigned DEF_DIV   = 125000000,
  parameter int unsigned DEF_HIGH  = 62500000,
  localparam int         CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic [CH_NUM-1:0]    en,
  input  logic                 sync,
  input  logic                 cfg_wr,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  input  logic [CNT_WIDTH-1:0] cfg_high,
  output logic                 cfg_err,
  output logic [CH_NUM-1:0]    pending,
  output logic [CH_NUM-1:0]    div_clk,
  output logic [CH_NUM-1:0]    tick
);

  // One extra bit so CH_NUM itself is representable when it is a power of 2.
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CH_NUM);

  ch_cfg_t wr_cfg;
  logic    ch_ok, wr_ok;
  logic    cfg_err_q, cfg_err_d;

  assign wr_cfg    = '{div: CNT_W'(cfg_div), high: CNT_W'(cfg_high)};
  assign ch_ok     = ({1'b0, cfg_ch} < CH_LIM);
  assign wr_ok     = cfg_wr && ch_ok && cfg_valid(wr_cfg.div, wr_cfg.high);
  assign cfg_err_d = cfg_wr && !wr_ok;

  always_ff @(posedge sclk) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    fre_div_ch #(
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_ch (
      .clk_i     (sclk),
      .rst_i     (rst),
      .en_i      (en[i]),
      .sync_i    (sync),
      .wr_i      (wr_ok && (cfg_ch == CH_W'(i))),
      .wr_cfg_i  (wr_cfg),
      .pending_o (pending[i]),
      .div_clk_o (div_clk[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

// File: doc/multi_fre_div.md
Name: multi_fre_div

Overview:
- Multi-channel programmable clock-enable/divided-clock generator; next generation of the single-channel fixed-limit divider.
- Each channel has a runtime-programmable period and high time, a per-channel enable and a period-start tick.
- Configuration goes through shadow registers and takes effect only at period boundaries, so outputs never glitch.
- Feeds timing strobes (LED/UART/sample ticks) to the rest of the design; a global sync realigns all channels.

Parameters:
CH_NUM, 4, number of independent channels (>=1)
CNT_WIDTH, 32, counter/divisor width in bits
DEF_DIV, 125000000, reset period of every channel in sclk cycles (2..2^CNT_WIDTH-1)
DEF_HIGH, 62500000, reset high time of every channel (0..DEF_DIV)

Ports:
sclk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active high
en  input  CH_NUM  per-channel enable
sync  input  1  realign all enabled channels to period start
cfg_wr  input  1  configuration write strobe, single cycle
cfg_ch  input  max(1,$clog2(CH_NUM))  target channel of write
cfg_div  input  CNT_WIDTH  new period (sclk cycles)
cfg_high  input  CNT_WIDTH  new high time (sclk cycles)
cfg_err  output  1  one-cycle pulse: last write rejected
pending  output  CH_NUM  shadow config waiting to be applied
div_clk  output  CH_NUM  divided output, registered
tick  output  CH_NUM  one-cycle pulse at period start, registered

Behaviour:
- Sync reset (rst=1 at an edge): cnt=0, div_act=DEF_DIV, high_act=DEF_HIGH, shadow=defaults, pending=0, div_clk=0, tick=0, cfg_err=0. Reset dominates every other input, including mid-period and mid-write.
- Per channel, en=1 at an edge:
  - div_clk <= (cnt < high_act); tick <= (cnt == 0).
  - cnt <= (cnt == div_act-1) ? 0 : cnt+1.
  - Output is therefore one cycle behind cnt. The first edge after enable gives tick=1 and div_clk=1 when high_act>0.
- Per channel, en=0 at an edge: cnt <= 0, div_clk <= 0, tick <= 0. If pending, the shadow is applied at that edge and pending clears.
- Config write (cfg_wr=1):
  - Valid when cfg_ch < CH_NUM, cfg_div >= 2 and cfg_high <= cfg_div.
  - Valid write: shadow[ch] <= {cfg_div, cfg_high}; pending[ch] <= 1. A later write before application overwrites the shadow (last write wins).
  - Invalid write: no state change; cfg_err=1 on the next cycle only.
- Application on an enabled channel: at the wrap edge (cnt == div_act-1) with pending=1, div_act/high_act <= shadow, pending <= 0, cnt <= 0. The next period uses the new values in full. A period is never truncated or stretched by a write.
- Write and wrap in the same cycle: the wrap applies the shadow as it stood before that edge, if pending. The new write lands in the shadow with pending=1 and applies at the following wrap.
- sync=1 at an edge (en=1):
  - cnt <= 0, div_clk <= 0, tick <= 0.
  - Pending shadows are applied at that edge.
  - All enabled channels start a period on the next edge with tick=1.
  - sync outranks wrap. Disabled channels are unaffected beyond their en=0 rule.
- Boundaries:
  - high_act=0: div_clk constantly 0, tick still pulses.
  - high_act=div_act: div_clk constantly 1 while enabled.
  - div_act=2, high=1: toggles every cycle.
  - Counter never exceeds div_act-1, so there is no overflow at CNT_WIDTH.
- Latency: config applied at most div_act cycles after the write on a running channel; 1 cycle on a disabled channel.

Decomposition:
- Package fre_div_pkg:
  - DIV_MIN=2 constant.
  - ch_cfg_t struct {div, high} sized by CNT_WIDTH (width parameterised via package parameter/localparam).
  - Validity check function cfg_valid(div, high).
- Sub-module fre_div_ch: one channel (cnt, active/shadow cfg, pending, div_clk, tick), instantiated CH_NUM times by a generate loop.
- Top holds write decode, range/validity check and the cfg_err register.

Test Plan:
- Reset then en[0]=1 with DEF_DIV=10, DEF_HIGH=5 -> div_clk[0] repeats 1×5, 0×5; tick[0] on the first enabled edge and every 10 cycles; others stay 0.
- Write ch1 div=4 high=1 mid-period of div=10 -> pending[1]=1 until the wrap; current period completes 10 cycles; then div_clk[1] reads 1,0,0,0 and pending clears.
- Writes div=1, high=5 with div=4, and cfg_ch=CH_NUM (CH_NUM non-power-of-2 build) -> cfg_err pulses one cycle each; div_clk/pending unchanged.
- Channels 0/1 at div=6/div=3 free-running, pulse sync -> both div_clk 0 for one cycle, then tick[0] and tick[1] together on the next edge; thereafter tick[1] every 3 and tick[0] every 6, coincident.
- Write on the exact wrap cycle, and rst asserted mid-period -> first case applies on the next wrap; second case: all outputs 0 and defaults restored at that edge, pending cleared.
- high=0, high=div, div=2/high=1 -> constant 0, constant 1, toggle every sclk; tick rate equals div in all three.
